// File: rtl/ex_mem_wb_pipe.sv
// ----------------------------------------------------------------------------
// ex_mem_wb_pipe
//
// Purpose:
//   This block holds the EX/MEM and MEM/WB pipeline registers. It sequences
//   data-memory loads and stores over a valid/ready request handshake followed
//   by a read-data-valid response. While a memory access is outstanding it
//   stalls the upstream stages. The EX/MEM and MEM/WB register contents are
//   the sources the EX-stage bypass network forwards from. The MEM/WB outputs
//   also drive the register-file write port.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   ex_*                 instruction fields presented by the EX stage
//   mem_stall            MEM cannot advance this cycle (combinational)
//   dmem_req/we/addr/    data-memory request (combinational from EX/MEM + FSM)
//   wdata/be
//   dmem_ready           request accepted this cycle
//   dmem_rvalid/rdata    load response
//   ex_mem_*             EX/MEM register contents (forwarding source)
//   ex_mem_is_load       valid load sitting in MEM (hazard unit)
//   mem_wb_*             MEM/WB register contents / register-file write port
//   mem_misaligned       access in MEM dropped as misaligned
// ----------------------------------------------------------------------------
module ex_mem_wb_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   // EX stage
   input  logic            ex_valid,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_store_data,
   // stall to upstream
   output logic            mem_stall,
   // data memory
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   // EX/MEM contents
   output logic [4:0]      ex_mem_rd,
   output logic            ex_mem_reg_write,
   output logic [XLEN-1:0] ex_mem_result,
   output logic            ex_mem_is_load,
   // MEM/WB contents
   output logic [4:0]      mem_wb_rd,
   output logic            mem_wb_reg_write,
   output logic [XLEN-1:0] mem_wb_data,
   output logic            mem_misaligned
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // EX/MEM register
   // ------------------------------------------------------------------------
   logic            exm_valid_q;
   logic [4:0]      exm_rd_q;
   logic            exm_reg_write_q;
   logic            exm_mem_read_q;
   logic            exm_mem_write_q;
   logic [2:0]      exm_funct3_q;
   logic [XLEN-1:0] exm_result_q;
   logic [XLEN-1:0] exm_store_data_q;

   // MEM/WB register
   logic            mwb_valid_q;
   logic [4:0]      mwb_rd_q;
   logic            mwb_reg_write_q;
   logic [XLEN-1:0] mwb_data_q;

   state_e          state_q;

   // ------------------------------------------------------------------------
   // MEM-stage decode
   // ------------------------------------------------------------------------
   logic            is_mem;
   logic            misaligned;
   logic            store_done;
   logic            load_done;
   logic            done;
   logic [1:0]      byte_off;

   assign byte_off = exm_result_q[1:0];
   assign is_mem   = exm_valid_q & (exm_mem_read_q | exm_mem_write_q);

   // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
   assign misaligned = is_mem &
                       (((exm_funct3_q[1:0] == 2'b01) & byte_off[0]) |
                        ((exm_funct3_q[1:0] == 2'b10) & (byte_off != 2'b00)));

   // A request is only presented from IDLE, so the WAIT state naturally
   // ignores dmem_ready and IDLE ignores dmem_rvalid.
   assign dmem_req   = is_mem & ~misaligned & (state_q == ST_IDLE);
   assign store_done = dmem_req & exm_mem_write_q & dmem_ready;
   assign load_done  = is_mem & (state_q == ST_WAIT) & dmem_rvalid;
   assign done       = store_done | load_done;

   assign mem_stall      = is_mem & ~misaligned & ~done;
   assign mem_misaligned = misaligned;

   assign dmem_we   = dmem_req & exm_mem_write_q;
   assign dmem_addr = {exm_result_q[XLEN-1:2], 2'b00};

   // ------------------------------------------------------------------------
   // Store lane replication and byte enables
   // ------------------------------------------------------------------------
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      dmem_wdata = exm_store_data_q;
      dmem_be    = 4'b1111;
      case (exm_funct3_q[1:0])
         2'b00: begin
            dmem_wdata = {4{exm_store_data_q[7:0]}};
            dmem_be    = 4'b0001 << byte_off;
         end
         2'b01: begin
            dmem_wdata = {2{exm_store_data_q[15:0]}};
            dmem_be    = 4'b0011 << byte_off;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Load extraction: move the addressed byte/half down to bit 0, then extend
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] ld_shift;
   logic [XLEN-1:0] ld_data;

   assign ld_shift = dmem_rdata >> {byte_off, 3'b000};

   always_comb begin
      ld_data = dmem_rdata;
      case (exm_funct3_q)
         3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of every other, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         exm_valid_q      <= 1'b0;
         exm_rd_q         <= '0;
         exm_reg_write_q  <= 1'b0;
         exm_mem_read_q   <= 1'b0;
         exm_mem_write_q  <= 1'b0;
         exm_funct3_q     <= '0;
         exm_result_q     <= '0;
         exm_store_data_q <= '0;
         mwb_valid_q      <= 1'b0;
         mwb_rd_q         <= '0;
         mwb_reg_write_q  <= 1'b0;
         mwb_data_q       <= '0;
         state_q          <= ST_IDLE;
      end else begin
         // EX/MEM holds the stalled instruction until its access completes.
         if (!mem_stall) begin
            exm_valid_q      <= ex_valid;
            exm_rd_q         <= ex_rd;
            exm_reg_write_q  <= ex_reg_write;
            exm_mem_read_q   <= ex_mem_read;
            exm_mem_write_q  <= ex_mem_write;
            exm_funct3_q     <= ex_funct3;
            exm_result_q     <= ex_alu_result;
            exm_store_data_q <= ex_store_data;
         end

         // A bubble goes into MEM/WB on every stall cycle so the stalled
         // instruction writes back exactly once, on the cycle it completes.
         if (mem_stall) begin
            mwb_valid_q     <= 1'b0;
            mwb_rd_q        <= '0;
            mwb_reg_write_q <= 1'b0;
            mwb_data_q      <= '0;
         end else begin
            mwb_valid_q     <= exm_valid_q;
            mwb_rd_q        <= exm_rd_q;
            mwb_reg_write_q <= exm_reg_write_q & ~misaligned;
            mwb_data_q      <= exm_mem_read_q ? ld_data : exm_result_q;
         end

         case (state_q)
            ST_IDLE: if (dmem_req && exm_mem_read_q && dmem_ready) state_q <= ST_WAIT;
            ST_WAIT: if (dmem_rvalid) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (reg_write gated by the owning stage's valid bit)
   // ------------------------------------------------------------------------
   assign ex_mem_rd        = exm_rd_q;
   assign ex_mem_reg_write = exm_valid_q & exm_reg_write_q;
   assign ex_mem_result    = exm_result_q;
   assign ex_mem_is_load   = exm_valid_q & exm_mem_read_q;

   assign mem_wb_rd        = mwb_rd_q;
   assign mem_wb_reg_write = mwb_valid_q & mwb_reg_write_q;
   assign mem_wb_data      = mwb_data_q;

endmodule

// File: doc/ex_mem_wb_pipe.md
# ex_mem_wb_pipe

Producer side of the EX-stage bypass network. It holds the EX/MEM and MEM/WB pipeline registers, sequences data-memory loads and stores through a valid/ready handshake, and stalls the upstream pipeline while a memory access is outstanding. Its EX/MEM and MEM/WB destination/write-enable/data outputs are the sources the forwarding logic selects from, and its MEM/WB outputs drive the register-file write port.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read / ex_mem_write  in  1 each  load / store; never both set.
- ex_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_alu_result  in  XLEN  ALU result, or effective address for a load or store.
- ex_store_data  in  XLEN  rs2 value, already forwarded.
- mem_stall  out  1  MEM cannot advance; upstream holds IF/ID/EX.
- dmem_req  out  1  access request.
- dmem_we  out  1  request is a store.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  full loaded word.
- ex_mem_rd, ex_mem_reg_write, ex_mem_result  out  5/1/XLEN  EX/MEM register contents.
- ex_mem_is_load  out  1  valid load in MEM; used by the hazard unit.
- mem_wb_rd, mem_wb_reg_write, mem_wb_data  out  5/1/XLEN  MEM/WB register contents and register-file write port.
- mem_misaligned  out  1  one-cycle pulse: the access in MEM was dropped as misaligned.

## Operation
- EX/MEM captures all ex_* fields, including valid, whenever mem_stall=0. It holds while mem_stall=1.
- reg_write outputs are gated by their stage's valid bit.
- Misaligned access:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - No dmem_req is issued.
  - mem_misaligned pulses while the instruction sits in MEM.
  - The instruction retires to MEM/WB with reg_write=0.
- A non-memory instruction advances after one cycle in MEM; mem_wb_data = ex_mem_result.
- FSM for a memory instruction in MEM:
  - IDLE: dmem_req=1. If dmem_ready=0, stay.
  - IDLE, store accepted: the store is done this cycle.
  - IDLE, load accepted: go to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid the load is done and the FSM returns to IDLE.
- mem_stall = ex_mem_valid & (mem_read | mem_write) & !misaligned & !done.
- While mem_stall=1, MEM/WB captures a bubble (valid=0, reg_write=0). This guarantees each instruction writes back exactly once.
- Load extraction (byte/half selected by addr[1:0]):
  - B/H are sign-extended.
  - BU/HU are zero-extended.
  - W is passed through unchanged.
- Store data and byte enables:
  - SB: byte replicated ×4, be=0001<<addr[1:0].
  - SH: half replicated ×2, be=0011<<addr[1:0].
  - SW: word as-is, be=1111.
- dmem_rvalid in IDLE, and dmem_ready in WAIT, are ignored.

## Timing
- Reset values:
  - Both valid bits = 0.
  - All rd = 0, reg_write = 0, data/result = 0.
  - FSM in IDLE.
  - dmem_req = mem_stall = mem_misaligned = ex_mem_is_load = 0.
- Latency: an instruction in EX in cycle N appears in EX/MEM in N+1 and in MEM/WB in N+2 when there are no stalls.
- dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are combinational from EX/MEM and the FSM. They stay stable from request until acceptance.
- mem_stall is combinational and may be asserted in the same cycle the instruction enters MEM.
- Load with dmem_ready and dmem_rvalid both arriving at the earliest possible cycle: exactly 1 stall cycle. Each additional wait cycle on either handshake adds 1 stall cycle.
- A store with dmem_ready=1 on its first cycle costs 0 stall cycles.
- Reset asserted mid-access, including in WAIT: the FSM returns to IDLE and pipeline state is cleared. A late dmem_rvalid after reset is ignored.
- Back-to-back loads: the second issues dmem_req in the cycle after the first completes.

## Test plan
- ALU sequence: rd=5, result 0x1234 in EX at cycle 0 → ex_mem_rd=5 at cycle 1; mem_wb_rd=5, mem_wb_data=0x1234 at cycle 2; no stall.
- LB at addr 0x103, dmem_rdata=0x80FF_FF00, ready immediate, rvalid next cycle → mem_stall high for 1 cycle; mem_wb_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at 0x202 with data 0xAAAA_BEEF and ready delayed 3 cycles → dmem_wdata=0xBEEFBEEF, be=1100, dmem_addr=0x200, stall for 3 cycles, mem_wb_reg_write=0.
- LW at 0x101 → no dmem_req; mem_misaligned pulses once; no stall; mem_wb_reg_write=0.
- Reset while in WAIT with rvalid arriving in the reset cycle → all outputs at reset values; the next load completes normally.
- rd=0 ALU op → mem_wb_reg_write=1, rd=0 passed through unchanged; a MEM/WB bubble during a stall → reg_write=0.
